// File: rtl/regfile_dump_ctrl_if.sv
// Control and debug-stream bundle for the register file dump walker.
// The master side is the walker; the slave side is the register file and the debug sink.
interface regfile_dump_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              start;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_last;

    modport master (
        input  start,
        output busy,
        output done,
        output rd_addr,
        input  rd_data,
        output dump_valid,
        input  dump_ready,
        output dump_addr,
        output dump_data,
        output dump_last
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  rd_addr,
        output rd_data,
        input  dump_valid,
        output dump_ready,
        input  dump_addr,
        input  dump_data,
        input  dump_last
    );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file through one read port and streams (index, value) beats
// on a valid/ready channel; one beat per READ_LAT+2 cycles when the sink never stalls.
module regfile_dump_ctrl #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1,
    parameter bit SKIP_X0  = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    regfile_dump_ctrl_if.master bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    // READ_LAT is capped at 4, so the remaining-wait count fits in two bits
    localparam int                CNT_W     = 2;
    localparam logic [CNT_W-1:0]  WAIT_INIT = CNT_W'(READ_LAT - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = SKIP_X0 ? ADDR_W'(1) : '0;
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);

    if (NUM_REGS > (1 << ADDR_W)) begin : g_bad_num_regs
        $error("regfile_dump_ctrl: NUM_REGS does not fit in ADDR_W bits");
    end
    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("regfile_dump_ctrl: READ_LAT must be 1..4");
    end

    logic [2:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [CNT_W-1:0]  cnt;
    logic              busy_q;
    logic              done_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              last_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_addr_q <= '0;
            valid_q   <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        idx    <= FIRST_IDX;
                        busy_q <= 1'b1;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    rd_addr_q <= idx;
                    cnt       <= WAIT_INIT;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    // rd_addr has been stable for READ_LAT edges when cnt reaches zero
                    if (cnt == '0) begin
                        data_q  <= bus.rd_data;
                        addr_q  <= idx;
                        valid_q <= 1'b1;
                        last_q  <= (idx == LAST_IDX);
                        state   <= S_SEND;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_SEND: begin
                    if (bus.dump_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (last_q) begin
                            state <= S_FIN;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_FIN: begin
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.dump_valid = valid_q;
    assign bus.dump_addr  = addr_q;
    assign bus.dump_data  = data_q;
    assign bus.dump_last  = last_q;

    a_valid_busy: assert property (@(posedge clk) disable iff (!rst) valid_q |-> busy_q);
    a_beat_hold: assert property (@(posedge clk) disable iff (!rst)
        (valid_q && !bus.dump_ready) |=> (valid_q && $stable(data_q) && $stable(addr_q)));
endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Bench for regfile_dump_ctrl: two configurations share one register file model;
// expected streams come from a snapshot of the register array plus the coherence rule.
module tb_regfile_dump_ctrl;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    typedef struct {
        bit sel;          // 0: READ_LAT=1 SKIP_X0=0, 1: READ_LAT=3 SKIP_X0=1
        int stall_beat;
        int stall_len;
        int restart_beat;
        bit rnd;
        int exp_first;
        int exp_beats;
        int exp_lat;      // -1: not checked
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic sel = 1'b0;
    logic start = 1'b0;
    logic ready = 1'b0;
    logic [DW-1:0] rf [NR];
    logic [DW-1:0] exp_rf [NR];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ia ();
    regfile_dump_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) ib ();

    assign ia.start      = start & ~sel;
    assign ib.start      = start & sel;
    assign ia.dump_ready = ready;
    assign ib.dump_ready = ready;
    assign ia.rd_data    = rf[ia.rd_addr];
    assign ib.rd_data    = rf[ib.rd_addr];

    regfile_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(1), .SKIP_X0(1'b0))
        dut_a (.clk(clk), .rst(rst), .bus(ia));
    regfile_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .SKIP_X0(1'b1))
        dut_b (.clk(clk), .rst(rst), .bus(ib));

    logic          o_busy, o_done, o_valid, o_last;
    logic [AW-1:0] o_addr, o_rdaddr;
    logic [DW-1:0] o_data;
    assign o_busy   = sel ? ib.busy       : ia.busy;
    assign o_done   = sel ? ib.done       : ia.done;
    assign o_valid  = sel ? ib.dump_valid : ia.dump_valid;
    assign o_last   = sel ? ib.dump_last  : ia.dump_last;
    assign o_addr   = sel ? ib.dump_addr  : ia.dump_addr;
    assign o_data   = sel ? ib.dump_data  : ia.dump_data;
    assign o_rdaddr = sel ? ib.rd_addr    : ia.rd_addr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input vec_t v, input int abort_beat, input bit coh);
        logic [AW-1:0] ga[$];
        logic [DW-1:0] gd[$];
        logic          gl[$];
        int stall_rem = v.stall_len;
        int cyc = 0;
        int done_cyc = -1;
        int dones = 0;
        bit restarted = 1'b0;
        bit wrote = 1'b0;
        bit pv = 1'b0;
        bit prdy = 1'b1;
        bit rdy;
        logic [AW-1:0] pa = '0;
        logic [DW-1:0] pd = '0;
        logic          pl = 1'b0;
        sel = v.sel;
        for (int i = 0; i < NR; i++) exp_rf[i] = rf[i];
        @(negedge clk);
        start = 1'b1;
        ready = 1'b1;
        for (int n = 0; n < 700; n++) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (cyc == 1) chk("busy_after_start", o_busy, 1);
            if (pv && !prdy) chk("beat_hold", {o_valid, o_last, o_addr, o_data}, {1'b1, pl, pa, pd});
            if (o_valid) chk("valid_implies_busy", o_busy, 1);
            if (o_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            // x5 not yet sampled, x2 already sampled: only x5's write may show up
            if (coh && !wrote && o_busy && o_rdaddr == AW'(3)) begin
                rf[5] = 32'hDEADBEEF;
                rf[2] = 32'hCAFEF00D;
                exp_rf[5] = 32'hDEADBEEF;
                wrote = 1'b1;
            end
            if (abort_beat >= 0 && o_valid && ga.size() == abort_beat) begin
                #2 rst = 1'b0;
                #1;
                chk("abort_busy", o_busy, 0);
                chk("abort_valid", o_valid, 0);
                chk("abort_done", o_done, 0);
                chk("abort_fields", {o_last, o_addr, o_data, o_rdaddr}, 0);
                repeat (2) @(negedge clk);
                rst = 1'b1;
                repeat (4) begin
                    @(negedge clk);
                    chk("abort_no_done", o_done, 0);
                end
                chk("abort_idle_busy", o_busy, 0);
                return;
            end
            if (v.rnd) rdy = ($urandom_range(0, 3) != 0);
            else if (o_valid && ga.size() == v.stall_beat && stall_rem > 0) begin
                rdy = 1'b0;
                stall_rem--;
            end else rdy = 1'b1;
            ready = rdy;
            if (o_valid && ga.size() == v.restart_beat && !restarted) begin
                start = 1'b1;
                restarted = 1'b1;
            end
            if (o_valid && rdy) begin
                ga.push_back(o_addr);
                gd.push_back(o_data);
                gl.push_back(o_last);
            end
            pv = o_valid; prdy = rdy; pa = o_addr; pd = o_data; pl = o_last;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        ready = 1'b0;
        chk("done_seen", done_cyc >= 0, 1);
        chk("done_pulses", dones, v.exp_lat < 0 && done_cyc < 0 ? 0 : 1);
        if (v.exp_lat >= 0) chk("done_latency", done_cyc - 1, v.exp_lat);
        chk("beat_count", ga.size(), v.exp_beats);
        for (int i = 0; i < ga.size() && i < v.exp_beats; i++) begin
            chk("beat_addr", ga[i], v.exp_first + i);
            chk("beat_data", gd[i], exp_rf[v.exp_first + i]);
            chk("beat_last", gl[i], (v.exp_first + i) == NR - 1);
        end
        chk("busy_after_done", o_busy, 0);
    endtask

    initial begin
        vec_t vt[5];
        vec_t rv;
        vt[0] = '{sel:0, stall_beat:-1, stall_len:0, restart_beat:-1, rnd:0, exp_first:0, exp_beats:32, exp_lat:97};
        vt[1] = '{sel:0, stall_beat:7,  stall_len:5, restart_beat:-1, rnd:0, exp_first:0, exp_beats:32, exp_lat:102};
        vt[2] = '{sel:0, stall_beat:-1, stall_len:0, restart_beat:10, rnd:0, exp_first:0, exp_beats:32, exp_lat:97};
        vt[3] = '{sel:1, stall_beat:-1, stall_len:0, restart_beat:-1, rnd:0, exp_first:1, exp_beats:31, exp_lat:156};
        vt[4] = '{sel:1, stall_beat:20, stall_len:3, restart_beat:-1, rnd:0, exp_first:1, exp_beats:31, exp_lat:159};
        for (int i = 0; i < NR; i++) rf[i] = DW'(i) * 32'h11111111;

        #1;
        chk("rst_a_ctrl", {ia.busy, ia.done, ia.dump_valid, ia.dump_last}, 0);
        chk("rst_a_fields", {ia.dump_addr, ia.dump_data, ia.rd_addr}, 0);
        chk("rst_b_ctrl", {ib.busy, ib.done, ib.dump_valid, ib.dump_last}, 0);
        chk("rst_b_fields", {ib.dump_addr, ib.dump_data, ib.rd_addr}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) run(vt[i], -1, 1'b0);

        run(vt[0], 15, 1'b0);
        run(vt[0], -1, 1'b0);
        run(vt[0], -1, 1'b1);

        for (int r = 0; r < 4; r++) begin
            rf[0] = '0;
            for (int i = 1; i < NR; i++) rf[i] = $urandom;
            rv = '{sel:r[0], stall_beat:-1, stall_len:0, restart_beat:-1, rnd:1,
                   exp_first:(r[0] ? 1 : 0), exp_beats:(r[0] ? 31 : 32), exp_lat:-1};
            run(rv, -1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
